// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM request path.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic [3:0] VRAM_MASK_ALL = 4'hF;
  localparam int         NUM_PORTS     = 2;

endpackage

// File: rtl/vram_arbiter.sv
// Round-robin arbiter serialising two requesters onto one registered VRAM port.
// Grant one cycle after sel, ack one cycle after vram_ack_i; losers simply hold sel until served.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  m0_sel_i,
  input  logic                  m0_wr_i,
  input  logic [3:0]            m0_mask_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_ack_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  input  logic                  m1_sel_i,
  input  logic                  m1_wr_i,
  input  logic [3:0]            m1_mask_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  vram_sel_o,
  output logic                  vram_wr_o,
  output logic [3:0]            vram_mask_o,
  output logic [ADDR_WIDTH-1:0] vram_addr_o,
  output logic [DATA_WIDTH-1:0] vram_data_out_o,
  input  logic [DATA_WIDTH-1:0] vram_data_in_i,
  input  logic                  vram_ack_i
);

  // Per-port request fields gathered into arrays so the grant index selects them.
  logic [NUM_PORTS-1:0]                 req;
  logic [NUM_PORTS-1:0]                 port_wr;
  logic [NUM_PORTS-1:0][3:0]            port_mask;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data;

  assign req       = {m1_sel_i,  m0_sel_i};
  assign port_wr   = {m1_wr_i,   m0_wr_i};
  assign port_mask = {m1_mask_i, m0_mask_i};
  assign port_addr = {m1_addr_i, m0_addr_i};
  assign port_data = {m1_data_i, m0_data_i};

  arb_state_e state_q, state_d;
  logic       last_grant_q;
  logic       gnt_idx;
  logic       grant_en;
  logic       done_en;

  logic [NUM_PORTS-1:0]                 ack_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_idx  = 1'b0;
    grant_en = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_en = 1'b1;
          state_d  = BUSY;
          // A tie goes to whichever port was not served last.
          gnt_idx  = (&req) ? ~last_grant_q : req[1];
        end
      end
      BUSY: begin
        if (vram_ack_i) begin
          done_en = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_grant_q doubles as the index of the port currently being served.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      last_grant_q    <= 1'b1;
      vram_sel_o      <= 1'b0;
      vram_wr_o       <= 1'b0;
      vram_mask_o     <= VRAM_MASK_ALL;
      vram_addr_o     <= '0;
      vram_data_out_o <= '0;
      ack_q           <= '0;
      rdata_q         <= '0;
    end else begin
      ack_q <= '0;
      if (grant_en) begin
        vram_sel_o      <= 1'b1;
        vram_wr_o       <= port_wr[gnt_idx];
        vram_mask_o     <= port_mask[gnt_idx];
        vram_addr_o     <= port_addr[gnt_idx];
        vram_data_out_o <= port_data[gnt_idx];
        last_grant_q    <= gnt_idx;
      end
      if (done_en) begin
        vram_sel_o            <= 1'b0;
        vram_wr_o             <= 1'b0;
        ack_q[last_grant_q]   <= 1'b1;
        if (!vram_wr_o) begin
          rdata_q[last_grant_q] <= vram_data_in_i;
        end
      end
    end
  end

  assign m0_ack_o  = ack_q[0];
  assign m1_ack_o  = ack_q[1];
  assign m0_data_o = rdata_q[0];
  assign m1_data_o = rdata_q[1];

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter: two requester drivers, a VRAM responder and a round-robin/memory model.
module tb_vram_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;

  typedef struct packed {
    logic          wr;
    logic [3:0]    mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic [1:0]    sel, wr, ack;
  logic [3:0]    mask0, mask1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1, rd0, rd1;
  logic          vram_sel_o, vram_wr_o, vram_ack_i;
  logic [3:0]    vram_mask_o;
  logic [AW-1:0] vram_addr_o;
  logic [DW-1:0] vram_data_out_o, vram_data_in_i;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_i(reset_i),
    .m0_sel_i(sel[0]), .m0_wr_i(wr[0]), .m0_mask_i(mask0), .m0_addr_i(addr0),
    .m0_data_i(wd0), .m0_ack_o(ack[0]), .m0_data_o(rd0),
    .m1_sel_i(sel[1]), .m1_wr_i(wr[1]), .m1_mask_i(mask1), .m1_addr_i(addr1),
    .m1_data_i(wd1), .m1_ack_o(ack[1]), .m1_data_o(rd1),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
    .vram_addr_o(vram_addr_o), .vram_data_out_o(vram_data_out_o),
    .vram_data_in_i(vram_data_in_i), .vram_ack_i(vram_ack_i)
  );

  int checks = 0;
  int failures = 0;

  req_t q0[$];
  req_t q1[$];
  req_t vlog[$];
  int   log_rd = 0;
  int   done_order[$];
  int   exp_order[$];
  bit   model_last = 1'b1;
  logic [DW-1:0] vmem    [logic [AW-1:0]];
  logic [DW-1:0] exp_mem [logic [AW-1:0]];

  int lat = 1;
  bit lat_rand = 1'b0;
  int force_req = 0;

  function automatic req_t mk(input logic w, input logic [3:0] m, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    req_t r;
    r.wr = w; r.mask = m; r.addr = a; r.data = d;
    return r;
  endfunction

  // Contents of a VRAM word never written during the run.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    if (a == 32'h55) return 16'hBEEF;
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return dflt(a);
  endfunction

  // Expected service order when every queued request stays pending: alternate while both
  // ports have work, then drain whichever is left.
  function automatic void build_rr(input int n0, input int n1);
    int  r0 = n0;
    int  r1 = n1;
    bit  last = model_last;
    exp_order.delete();
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) begin
        last = ~last;
      end else begin
        last = (r1 > 0);
      end
      exp_order.push_back(int'(last));
      if (last) r1--; else r0--;
    end
  endfunction

  function automatic int qsize(input int p);
    if (p == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic req_t qhead(input int p);
    if (p == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void qpop(input int p);
    if (p == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int p);
    if (p == 0) return rd0;
    return rd1;
  endfunction

  task automatic drive_port(input int p, input req_t r);
    if (p == 0) begin
      wr[0] = r.wr; mask0 = r.mask; addr0 = r.addr; wd0 = r.data;
    end else begin
      wr[1] = r.wr; mask1 = r.mask; addr1 = r.addr; wd1 = r.data;
    end
  endtask

  // VRAM responder: acks after lat cycles of sel, records every completed transaction.
  initial begin
    int cnt = 0;
    int cur_lat = 1;
    int force_done = 0;
    vram_ack_i = 1'b0;
    vram_data_in_i = '0;
    forever begin
      @(posedge clk); #1;
      vram_ack_i = 1'b0;
      if (force_req != force_done) begin
        force_done = force_req;
        vram_ack_i = 1'b1;
        vram_data_in_i = 16'hDEAD;
      end else if (reset_i && vram_sel_o) begin
        if (cnt == 0) cur_lat = lat_rand ? int'($urandom_range(1, 3)) : lat;
        cnt++;
        if (cnt >= cur_lat) begin
          vram_ack_i = 1'b1;
          if (vram_wr_o) vmem[vram_addr_o] = vram_data_out_o;
          else vram_data_in_i = vmem.exists(vram_addr_o) ? vmem[vram_addr_o] : dflt(vram_addr_o);
          vlog.push_back(mk(vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o));
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Runs both requester queues to completion, checking each served transaction.
  task automatic run_ports(input int budget);
    int   cyc = 0;
    bit   prev_ack [2] = '{1'b0, 1'b0};
    req_t r, d;
    done_order.delete();
    while ((q0.size() > 0 || q1.size() > 0 || sel != 2'b00) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          checks++;
          if (!sel[p] || prev_ack[p]) begin
            failures++;
            $display("FAIL ack_unexpected port=%0d sel=%0b prev_ack=%0b", p, sel[p], prev_ack[p]);
          end else begin
            r = qhead(p);
            checks++;
            if (log_rd >= vlog.size()) begin
              failures++;
              $display("FAIL ack_without_vram port=%0d addr=%0h", p, r.addr);
            end else begin
              d = vlog[log_rd];
              log_rd++;
              if ({d.wr, d.mask, d.addr} !== {r.wr, r.mask, r.addr} || (r.wr && d.data !== r.data))
              begin
                failures++;
                $display("FAIL vram_fields port=%0d got wr=%0b m=%0h a=%0h d=%0h exp wr=%0b m=%0h a=%0h d=%0h",
                         p, d.wr, d.mask, d.addr, d.data, r.wr, r.mask, r.addr, r.data);
              end
            end
            if (!r.wr) begin
              checks++;
              if (get_rdata(p) !== model_rd(r.addr)) begin
                failures++;
                $display("FAIL read_data port=%0d addr=%0h got=%0h exp=%0h",
                         p, r.addr, get_rdata(p), model_rd(r.addr));
              end
            end else begin
              exp_mem[r.addr] = r.data;
            end
            done_order.push_back(p);
            model_last = p[0];
            qpop(p);
            sel[p] = 1'b0;
          end
        end else if (!sel[p] && qsize(p) > 0) begin
          drive_port(p, qhead(p));
          sel[p] = 1'b1;
        end
        prev_ack[p] = ack[p];
      end
    end
    checks++;
    if (cyc >= budget) begin
      failures++;
      $display("FAIL run_timeout left0=%0d left1=%0d sel=%b", q0.size(), q1.size(), sel);
      q0.delete(); q1.delete(); sel = 2'b00;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    model_last = 1'b1;
    log_rd = vlog.size();
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({vram_sel_o, vram_wr_o, vram_mask_o} !== 6'b00_1111) begin
      failures++;
      $display("FAIL reset_ctrl got sel=%0b wr=%0b mask=%0h exp 0 0 f", vram_sel_o, vram_wr_o, vram_mask_o);
    end
    checks++;
    if (vram_addr_o !== '0 || vram_data_out_o !== '0) begin
      failures++;
      $display("FAIL reset_bus got addr=%0h data=%0h exp 0 0", vram_addr_o, vram_data_out_o);
    end
    checks++;
    if (ack !== 2'b00 || rd0 !== '0 || rd1 !== '0) begin
      failures++;
      $display("FAIL reset_ports got ack=%b rd0=%0h rd1=%0h exp 0", ack, rd0, rd1);
    end
    reset_i = 1'b1;
    model_last = 1'b1;
    log_rd = vlog.size();
  endtask

  task automatic test_single_write();
    int n = 0;
    bit got = 1'b0;
    lat = 2;
    @(posedge clk); #1;
    drive_port(0, mk(1'b1, 4'hF, 32'h10, 16'h1234));
    sel[0] = 1'b1;
    while (n < 10 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        checks++;
        if ({vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o} !==
            {1'b1, 1'b1, 4'hF, 32'h10, 16'h1234}) begin
          failures++;
          $display("FAIL write_grant got sel=%0b wr=%0b m=%0h a=%0h d=%0h exp 1 1 f 10 1234",
                   vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o);
        end
      end
      checks++;
      if (ack[1] !== 1'b0) begin
        failures++;
        $display("FAIL write_port1_ack got=%0b exp=0", ack[1]);
      end
      if (ack[0]) begin
        got = 1'b1;
        sel[0] = 1'b0;
      end
    end
    checks++;
    if (!got || n != 3) begin
      failures++;
      $display("FAIL write_ack_latency got=%0d cycles acked=%0b exp=3", n, got);
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 2'b00 || vram_sel_o !== 1'b0 || rd1 !== '0) begin
      failures++;
      $display("FAIL write_release got ack=%b vsel=%0b rd1=%0h exp 0 0 0", ack, vram_sel_o, rd1);
    end
    log_rd = vlog.size();
    exp_mem[32'h10] = 16'h1234;
    model_last = 1'b0;
    lat = 1;
  endtask

  task automatic test_read_port1();
    q1.push_back(mk(1'b0, 4'hF, 32'h55, 16'h0));
    run_ports(50);
    checks++;
    if (done_order.size() != 1 || done_order[0] != 1) begin
      failures++;
      $display("FAIL read_order got n=%0d exp n=1 port 1", done_order.size());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rd1 !== 16'hBEEF || rd0 !== '0) begin
      failures++;
      $display("FAIL read_hold got rd1=%0h rd0=%0h exp beef 0", rd1, rd0);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      int n = (round == 0) ? 1 : 4;
      for (int i = 0; i < n; i++) begin
        q0.push_back(mk(1'b1, 4'h3, 32'h100 + i, 16'h0A00 + i[15:0]));
        q1.push_back(mk(1'b1, 4'hC, 32'h200 + i, 16'h0B00 + i[15:0]));
      end
      build_rr(n, n);
      run_ports(200);
      ok = (done_order.size() == exp_order.size());
      for (int i = 0; i < exp_order.size() && ok; i++) ok = (done_order[i] == exp_order[i]);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_order round=%0d got n=%0d first=%0d exp n=%0d first=%0d", round,
                 done_order.size(), (done_order.size() > 0) ? done_order[0] : -1,
                 exp_order.size(), exp_order[0]);
      end
    end
  endtask

  task automatic test_fill();
    int base = vlog.size();
    for (int i = 0; i < 16; i++) q0.push_back(mk(1'b1, 4'hF, i, i[15:0]));
    run_ports(300);
    checks++;
    if (vlog.size() - base != 16 || done_order.size() != 16) begin
      failures++;
      $display("FAIL fill_count got vram=%0d acks=%0d exp 16", vlog.size() - base, done_order.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (vlog[base + i].addr !== i || vlog[base + i].data !== i[15:0]) begin
          failures++;
          $display("FAIL fill_word i=%0d got a=%0h d=%0h exp %0h", i, vlog[base + i].addr,
                   vlog[base + i].data, i);
        end
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    int n = 0;
    lat = 1000;
    @(posedge clk); #1;
    drive_port(0, mk(1'b1, 4'h5, 32'h20, 16'h7777));
    sel[0] = 1'b1;
    while (n < 5 && !vram_sel_o) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!vram_sel_o) begin
      failures++;
      $display("FAIL busy_grant got vsel=%0b exp=1", vram_sel_o);
    end
    #3 reset_i = 1'b0;
    #1;
    checks++;
    if ({vram_sel_o, vram_wr_o, vram_mask_o, ack} !== 8'b0011_1100 || vram_addr_o !== '0) begin
      failures++;
      $display("FAIL async_reset got vsel=%0b wr=%0b m=%0h ack=%b a=%0h exp 0 0 f 0 0",
               vram_sel_o, vram_wr_o, vram_mask_o, ack, vram_addr_o);
    end
    checks++;
    if (rd0 !== '0 || rd1 !== '0) begin
      failures++;
      $display("FAIL async_reset_data got rd0=%0h rd1=%0h exp 0 0", rd0, rd1);
    end
    sel[0] = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b1;
    lat = 1;
    model_last = 1'b1;
    log_rd = vlog.size();
    q1.push_back(mk(1'b0, 4'hF, 32'h3, 16'h0));
    run_ports(50);
    checks++;
    if (done_order.size() != 1 || done_order[0] != 1) begin
      failures++;
      $display("FAIL post_reset_grant got n=%0d exp n=1 port 1", done_order.size());
    end
  endtask

  task automatic test_spurious_ack();
    int base;
    @(posedge clk); #1;
    force_req++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 2'b00 || vram_sel_o !== 1'b0) begin
        failures++;
        $display("FAIL spurious_ack cycle=%0d got ack=%b vsel=%0b exp 0 0", i, ack, vram_sel_o);
      end
    end
    base = vlog.size();
    q0.push_back(mk(1'b1, 4'h9, 32'h40, 16'h4242));
    run_ports(50);
    checks++;
    if (done_order.size() != 1 || done_order[0] != 0 || vlog.size() - base != 1) begin
      failures++;
      $display("FAIL after_spurious got acks=%0d vram=%0d exp 1 1", done_order.size(), vlog.size() - base);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] rv;
    lat_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rv = $urandom;
      if (rv[0]) q1.push_back(mk(rv[1], rv[5:2], {29'd0, rv[8:6]}, rv[31:16]));
      else       q0.push_back(mk(rv[1], rv[5:2], {29'd0, rv[8:6]}, rv[31:16]));
    end
    build_rr(q0.size(), q1.size());
    run_ports(800);
    ok = (done_order.size() == exp_order.size());
    for (int i = 0; i < exp_order.size() && ok; i++) ok = (done_order[i] == exp_order[i]);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL random_order got n=%0d exp n=%0d", done_order.size(), exp_order.size());
    end
    lat_rand = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0;
    sel = 2'b00; wr = 2'b00;
    mask0 = 4'h0; mask1 = 4'h0; addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    test_reset();
    test_single_write();
    test_read_port1();
    test_simultaneous();
    test_fill();
    test_reset_mid_busy();
    test_spurious_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
